// File: rtl/alu_instr_encoder.sv
// alu_instr_encoder: turns ALUControl requests into RV32I R/I-type words and
// writes them sequentially into instruction memory.
module alu_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [2:0]                   req_alu_ctrl,
  input  logic                         req_imm_sel,
  input  logic [4:0]                   req_rd,
  input  logic [4:0]                   req_rs1,
  input  logic [4:0]                   req_rs2,
  input  logic [11:0]                  req_imm,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic                         mem_ready,
  output logic [$clog2(DEPTH+1)-1:0]   instr_count,
  output logic                         full,
  output logic                         err_illegal
);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;
  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, enc;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d, is_sub, illegal;
  logic [2:0]    f3;
  assign is_sub  = req_alu_ctrl == 3'b001;
  assign illegal = req_alu_ctrl == 3'b100 || req_alu_ctrl[2:1] == 2'b11 || (is_sub && req_imm_sel);
  assign f3 = (req_alu_ctrl == 3'b101) ? 3'b010 :
              (req_alu_ctrl == 3'b011) ? 3'b110 :
              (req_alu_ctrl == 3'b010) ? 3'b111 : 3'b000;
  assign enc = req_imm_sel ? {req_imm, req_rs1, f3, req_rd, 7'b0010011}
                           : {is_sub ? 7'b0100000 : 7'b0000000, req_rs2, req_rs1, f3, req_rd, 7'b0110011};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end
  // clear outranks both acceptance and write completion
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    if (clear) begin
      state_d = S_IDLE;
      addr_d  = BASE_ADDR;
      count_d = '0;
      err_d   = 1'b0;
    end else if (state_q == S_IDLE && req_valid) begin
      err_d   = err_q | illegal;
      state_d = illegal ? S_IDLE : S_WRITE;
      wdata_d = illegal ? wdata_q : enc;
    end else if (state_q == S_WRITE && mem_ready) begin
      addr_d  = addr_q + 32'd4;
      count_d = count_q + CW'(1);
      state_d = (count_q == CW'(DEPTH-1)) ? S_FULL : S_IDLE;
    end
  end
  always_comb begin
    req_ready   = rst && !clear && state_q == S_IDLE;
    mem_we      = state_q == S_WRITE;
    full        = state_q == S_FULL;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    instr_count = count_q;
    err_illegal = err_q;
  end
endmodule
